// File: rtl/uart_transmitter.sv
// rtl/uart_transmitter.sv - UART transmitter: start/busy byte handshake, 11-bit frame (start, 8 data LSB-first, parity, stop)
module uart_transmitter #(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter bit          PARITY_ODD   = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_start,
    input  logic [7:0] tx_data_in,
    output logic       tx_data_out,
    output logic       tx_busy,
    output logic       tx_done
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        DONE   = 3'd5
    } state_t;

    localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);

    state_t      state;
    logic [15:0] baud_cnt;
    logic [2:0]  bit_idx;
    logic [7:0]  shift;
    logic        parity_bit;
    logic        baud_last;

    assign baud_last = (baud_cnt == BAUD_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            baud_cnt    <= '0;
            bit_idx     <= '0;
            shift       <= '0;
            parity_bit  <= 1'b0;
            tx_data_out <= 1'b1;
            tx_busy     <= 1'b0;
            tx_done     <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            case (state)
                // DONE accepts a new byte exactly like IDLE so held tx_start streams frames
                IDLE, DONE: begin
                    baud_cnt    <= '0;
                    bit_idx     <= '0;
                    tx_data_out <= 1'b1;
                    tx_busy     <= 1'b0;
                    if (tx_start) begin
                        shift       <= tx_data_in;
                        parity_bit  <= (^tx_data_in) ^ PARITY_ODD;
                        state       <= START;
                        tx_data_out <= 1'b0;
                        tx_busy     <= 1'b1;
                    end else begin
                        state <= IDLE;
                    end
                end
                START: begin
                    if (baud_last) begin
                        state       <= DATA;
                        baud_cnt    <= '0;
                        bit_idx     <= '0;
                        tx_data_out <= shift[0];
                        shift       <= {1'b0, shift[7:1]};
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
                DATA: begin
                    if (baud_last) begin
                        baud_cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            state       <= PARITY;
                            tx_data_out <= parity_bit;
                        end else begin
                            bit_idx     <= bit_idx + 3'd1;
                            tx_data_out <= shift[0];
                            shift       <= {1'b0, shift[7:1]};
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
                PARITY: begin
                    if (baud_last) begin
                        state       <= STOP;
                        baud_cnt    <= '0;
                        tx_data_out <= 1'b1;
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
                STOP: begin
                    if (baud_last) begin
                        state       <= DONE;
                        baud_cnt    <= '0;
                        tx_data_out <= 1'b1;
                        tx_busy     <= 1'b0;
                        tx_done     <= 1'b1;
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
                default: begin
                    state       <= IDLE;
                    baud_cnt    <= '0;
                    bit_idx     <= '0;
                    tx_data_out <= 1'b1;
                    tx_busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule
